// File: rtl/road_fighter_pkg.sv
// ============================================================================
// road_fighter_pkg
// Shared colour, speed and crash-state definitions for the road fighter core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package road_fighter_pkg;

    localparam logic [7:0] MASK_VALUE = 8'h62;
    localparam logic [9:0] SPEED_MAX  = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CRASH   = 2'd1,
        RECOVER = 2'd2
    } crash_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_down_counter.sv
// ============================================================================
// frame_down_counter
// Loadable frame counter stepped by frame_start; holds at zero, flags zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_down_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             frame_start,
    input  logic             step_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over stepping so a reload on a frame boundary is never lost.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (frame_start && step_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/car_collision_compositor.sv
// ============================================================================
// car_collision_compositor
// Priority compositing of player/AI car pixels plus per-frame crash handling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module car_collision_compositor #(
    parameter int         NUM_AI         = 4,
    parameter logic [7:0] MASK_VALUE     = road_fighter_pkg::MASK_VALUE,
    parameter int         CRASH_FRAMES   = 60,
    parameter int         RECOVER_FRAMES = 90,
    parameter int         BLINK_FRAMES   = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame_start,
    input  logic [7:0]             player_color,
    input  logic [NUM_AI-1:0][7:0] ai_colors,
    output logic [7:0]             out_color,
    output logic                   out_draw,
    output logic [NUM_AI-1:0]      hit_mask,
    output logic                   collision_pulse,
    output logic                   crash_active,
    output logic                   invulnerable,
    output logic [9:0]             speed_cap
);

    import road_fighter_pkg::*;

    localparam int MAX_FRAMES = (CRASH_FRAMES > RECOVER_FRAMES) ? CRASH_FRAMES : RECOVER_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);
    localparam int BW         = $clog2(BLINK_FRAMES + 1);

    crash_state_t      state_q,   state_d;
    logic [NUM_AI-1:0] hit_acc_q, hit_acc_d;
    logic [NUM_AI-1:0] hit_mask_q;
    logic              pulse_q,   pulse_d;
    logic              visible_q, visible_d;
    logic [7:0]        color_q,   color_d;
    logic              draw_q;

    logic              in_idle;
    logic              player_opaque;
    logic [NUM_AI-1:0] overlap;
    logic              frame_load, blink_load, clear_acc;
    logic [CW-1:0]     frame_load_value;
    logic              frame_zero, blink_zero;

    assign in_idle       = (state_q == IDLE);
    assign player_opaque = (player_color != MASK_VALUE);

    for (genvar gi = 0; gi < NUM_AI; gi++) begin : g_overlap
        assign overlap[gi] = in_idle & player_opaque & (ai_colors[gi] != MASK_VALUE);
    end

    // Lowest priority first so the highest-priority opaque source overwrites last.
    always_comb begin
        color_d = MASK_VALUE;
        for (int i = NUM_AI - 1; i >= 0; i--) begin
            if (ai_colors[i] != MASK_VALUE) color_d = ai_colors[i];
        end
        if (visible_q && player_opaque) color_d = player_color;
    end

    always_comb begin
        state_d          = state_q;
        visible_d        = visible_q;
        pulse_d          = 1'b0;
        frame_load       = 1'b0;
        frame_load_value = CW'(CRASH_FRAMES - 1);
        blink_load       = 1'b0;
        clear_acc        = 1'b0;
        if (frame_start) begin
            if (!in_idle && blink_zero) begin
                blink_load = 1'b1;
                visible_d  = ~visible_q;
            end
            case (state_q)
                IDLE: begin
                    if (hit_acc_q != '0) begin
                        state_d    = CRASH;
                        pulse_d    = 1'b1;
                        frame_load = 1'b1;
                        blink_load = 1'b1;
                        visible_d  = 1'b0;
                    end
                end
                CRASH: begin
                    if (frame_zero) begin
                        state_d          = RECOVER;
                        frame_load       = 1'b1;
                        frame_load_value = CW'(RECOVER_FRAMES - 1);
                    end
                end
                RECOVER: begin
                    if (frame_zero) begin
                        state_d   = IDLE;
                        visible_d = 1'b1;
                        clear_acc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The frame_start cycle already belongs to the new frame, so its overlap seeds the accumulator.
    always_comb begin
        hit_acc_d = hit_acc_q | overlap;
        if (clear_acc) begin
            hit_acc_d = '0;
        end else if (frame_start) begin
            hit_acc_d = overlap;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            hit_acc_q  <= '0;
            hit_mask_q <= '0;
            pulse_q    <= 1'b0;
            visible_q  <= 1'b1;
            color_q    <= MASK_VALUE;
            draw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_acc_q  <= hit_acc_d;
            pulse_q    <= pulse_d;
            visible_q  <= visible_d;
            color_q    <= color_d;
            draw_q     <= (color_d != MASK_VALUE);
            if (frame_start) hit_mask_q <= hit_acc_q;
        end
    end

    frame_down_counter #(.WIDTH(CW)) u_frame_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .frame_start(frame_start),
        .step_en    (!in_idle),
        .load       (frame_load),
        .load_value (frame_load_value),
        .zero       (frame_zero)
    );

    frame_down_counter #(.WIDTH(BW)) u_blink_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .frame_start(frame_start),
        .step_en    (!in_idle),
        .load       (blink_load),
        .load_value (BW'(BLINK_FRAMES - 1)),
        .zero       (blink_zero)
    );

    assign out_color       = color_q;
    assign out_draw        = draw_q;
    assign hit_mask        = hit_mask_q;
    assign collision_pulse = pulse_q;
    assign crash_active    = (state_q == CRASH);
    assign invulnerable    = (state_q != IDLE);
    assign speed_cap       = (state_q == CRASH) ? 10'd0 : SPEED_MAX;

endmodule

`default_nettype wire
